// File: rtl/ob_cmd_ingress.sv
// ---------------------------------------------------------------------------
// ob_cmd_ingress
//
// Ingress stage in front of the order-book engine. Commands arrive from the
// host on a valid/ready handshake. Each accepted command is classified by its
// opcode:
//   - Buy / Sell / QryBidAsk : written into an N-entry FIFO and presented to
//                              the engine in arrival order.
//   - Nop                    : retired here; a single-entry response register
//                              is loaded with {uid, S_Okay}.
//   - reserved (3'b1xx)      : dropped; drop_cnt counts them and saturates.
//
// Command layout (35 bits): uid[34:3], opcode[2:0].
// Response layout (35 bits): uid[34:3], status[2:0].
//
// Ports
//   clk          in   clock, rising edge
//   arst_n       in   asynchronous active-low reset
//   cmd_in_vld   in   upstream command valid
//   cmd_in       in   upstream command
//   cmd_in_rdy   out  ingress accepts this cycle (registered state only)
//   cmd_out_vld  out  FIFO head valid toward the engine
//   cmd_out      out  FIFO head command
//   cmd_out_rdy  in   engine accepts the head
//   rsp_out_vld  out  local Nop response valid
//   rsp_out      out  local Nop response
//   rsp_out_rdy  in   response consumer accepts
//   occupancy    out  number of valid FIFO entries
//   drop_cnt     out  reserved-opcode drop count, saturating
// ---------------------------------------------------------------------------
module ob_cmd_ingress #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 cmd_in_vld,
    input  logic [34:0]          cmd_in,
    output logic                 cmd_in_rdy,
    output logic                 cmd_out_vld,
    output logic [34:0]          cmd_out,
    input  logic                 cmd_out_rdy,
    output logic                 rsp_out_vld,
    output logic [34:0]          rsp_out,
    input  logic                 rsp_out_rdy,
    output logic [$clog2(N):0]   occupancy,
    output logic [15:0]          drop_cnt
);

    localparam int PW = $clog2(N);
    localparam int OW = PW + 1;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_BUY     = 3'b001;
    localparam logic [2:0] OP_SELL    = 3'b010;
    localparam logic [2:0] OP_QRY     = 3'b011;
    localparam logic [2:0] S_OKAY     = 3'b000;
    localparam logic [15:0] DROP_MAX  = 16'hFFFF;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [34:0]   mem_q [N];
    logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [OW-1:0] occ_q,     occ_d;
    logic          rsp_vld_q, rsp_vld_d;
    logic [34:0]   rsp_q,     rsp_d;
    logic [15:0]   drop_q,    drop_d;

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic [2:0] in_op;
    logic       full;
    logic       empty;
    logic       in_acc;
    logic       is_fwd;
    logic       is_nop;
    logic       is_rsv;
    logic       push;
    logic       pop;
    logic       rsp_done;

    assign in_op = cmd_in[2:0];
    assign full  = (occ_q == OW'(N));
    assign empty = (occ_q == '0);

    // Ready depends only on registered state. A full FIFO refuses even when
    // the head is being popped in the same cycle, which keeps input ready
    // free of any path from cmd_out_rdy.
    assign cmd_in_rdy = !full && !rsp_vld_q;

    assign in_acc = cmd_in_vld && cmd_in_rdy;

    always_comb begin
        is_fwd = 1'b0;
        is_nop = 1'b0;
        is_rsv = 1'b0;
        case (in_op)
            OP_NOP:                   is_nop = 1'b1;
            OP_BUY, OP_SELL, OP_QRY:  is_fwd = 1'b1;
            default:                  is_rsv = 1'b1;
        endcase
    end

    assign push     = in_acc && is_fwd;
    assign pop      = !empty && cmd_out_rdy;
    assign rsp_done = rsp_vld_q && rsp_out_rdy;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // Pointers are PW bits wide; with N a power of two the natural
        // overflow of the increment is the modulo-N wrap.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        rsp_vld_d = rsp_vld_q;
        rsp_d     = rsp_q;
        // A Nop can only be accepted while the response register is empty,
        // so the clear and the load never compete in one cycle. The payload
        // is left untouched on clear; only the valid flag drops.
        if (rsp_done) begin
            rsp_vld_d = 1'b0;
        end
        if (in_acc && is_nop) begin
            rsp_vld_d = 1'b1;
            rsp_d     = {cmd_in[34:3], S_OKAY};
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (in_acc && is_rsv && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_q     <= '0;
            drop_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_q     <= rsp_d;
            drop_q    <= drop_d;
        end
    end

    // Storage needs no reset: an entry is only visible once occupancy
    // covers it, and reset forces occupancy to zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cmd_out_vld = !empty;
    assign cmd_out     = mem_q[rd_ptr_q];
    assign rsp_out_vld = rsp_vld_q;
    assign rsp_out     = rsp_q;
    assign occupancy   = occ_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_ob_cmd_ingress.sv
module tb_ob_cmd_ingress;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        cmd_in_vld;
    logic [34:0] cmd_in;
    logic        cmd_in_rdy;
    logic        cmd_out_vld;
    logic [34:0] cmd_out;
    logic        cmd_out_rdy;
    logic        rsp_out_vld;
    logic [34:0] rsp_out;
    logic        rsp_out_rdy;
    logic [2:0]  occupancy;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    ob_cmd_ingress #(.N(N)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .cmd_in_vld  (cmd_in_vld),
        .cmd_in      (cmd_in),
        .cmd_in_rdy  (cmd_in_rdy),
        .cmd_out_vld (cmd_out_vld),
        .cmd_out     (cmd_out),
        .cmd_out_rdy (cmd_out_rdy),
        .rsp_out_vld (rsp_out_vld),
        .rsp_out     (rsp_out),
        .rsp_out_rdy (rsp_out_rdy),
        .occupancy   (occupancy),
        .drop_cnt    (drop_cnt)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model: a queue of forwarded commands, a pending-response
    // flag with its payload, and an integer drop count.
    logic [34:0] m_q[$];
    bit          m_rsp_vld;
    logic [34:0] m_rsp;
    int          m_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rsp_vld = 0;
        m_rsp     = '0;
        m_drop    = 0;
    endtask

    task automatic check_model();
        chk("m_in_rdy",  64'(cmd_in_rdy),  64'((m_q.size() < N) && !m_rsp_vld));
        chk("m_out_vld", 64'(cmd_out_vld), 64'(m_q.size() > 0));
        chk("m_occ",     64'(occupancy),   64'(m_q.size()));
        chk("m_rsp_vld", 64'(rsp_out_vld), 64'(m_rsp_vld));
        chk("m_drop",    64'(drop_cnt),    64'(m_drop));
        if (m_q.size() > 0) chk("m_out", 64'(cmd_out), 64'(m_q[0]));
        if (m_rsp_vld)      chk("m_rsp", 64'(rsp_out), 64'(m_rsp));
    endtask

    // One clock: the model decides from pre-edge inputs, the clock advances,
    // the model commits, and all outputs are compared 1 time unit later.
    task automatic cyc();
        bit          acc, pop, rclr;
        logic [34:0] c;
        acc  = cmd_in_vld && (m_q.size() < N) && !m_rsp_vld;
        pop  = (m_q.size() > 0) && cmd_out_rdy;
        rclr = m_rsp_vld && rsp_out_rdy;
        c    = cmd_in;
        @(posedge clk);
        #1;
        if (pop)  void'(m_q.pop_front());
        if (rclr) m_rsp_vld = 0;
        if (acc) begin
            if (c[2:0] == 3'b000) begin
                m_rsp_vld = 1;
                m_rsp     = {c[34:3], 3'b000};
            end else if (c[2] == 1'b0) begin
                m_q.push_back(c);
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
        check_model();
    endtask

    task automatic set_in(input logic vld, input logic [2:0] op, input logic [31:0] uid);
        cmd_in_vld = vld;
        cmd_in     = {uid, op};
    endtask

    typedef struct {
        logic        vld;
        logic [2:0]  op;
        logic [31:0] uid;
        logic        out_rdy;
        logic        exp_in_rdy;
        logic        exp_out_vld;
        logic [31:0] exp_uid;
        logic [2:0]  exp_occ;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int exp_uid;
        logic [31:0] drain_exp[4];

        vecs[0] = '{1'b1, 3'b001, 32'd1, 1'b1, 1'b1, 1'b1, 32'd1, 3'd1};
        vecs[1] = '{1'b1, 3'b010, 32'd2, 1'b1, 1'b1, 1'b1, 32'd2, 3'd1};
        vecs[2] = '{1'b1, 3'b011, 32'd3, 1'b1, 1'b1, 1'b1, 32'd3, 3'd1};
        vecs[3] = '{1'b0, 3'b000, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 3'd0};

        model_reset();
        arst_n      = 1'b0;
        set_in(1'b0, 3'b000, 32'd0);
        cmd_out_rdy = 1'b0;
        rsp_out_rdy = 1'b0;
        #12;
        chk("rst_in_rdy",  64'(cmd_in_rdy),  64'd1);
        chk("rst_out_vld", 64'(cmd_out_vld), 64'd0);
        chk("rst_rsp_vld", 64'(rsp_out_vld), 64'd0);
        chk("rst_rsp",     64'(rsp_out),     64'd0);
        chk("rst_occ",     64'(occupancy),   64'd0);
        chk("rst_drop",    64'(drop_cnt),    64'd0);
        #1 arst_n = 1'b1;

        // Back-to-back Buy/Sell/Qry with the engine always ready.
        for (int i = 0; i < 4; i++) begin
            set_in(vecs[i].vld, vecs[i].op, vecs[i].uid);
            cmd_out_rdy = vecs[i].out_rdy;
            cyc();
            chk("vec_in_rdy",  64'(cmd_in_rdy),  64'(vecs[i].exp_in_rdy));
            chk("vec_out_vld", 64'(cmd_out_vld), 64'(vecs[i].exp_out_vld));
            chk("vec_occ",     64'(occupancy),   64'(vecs[i].exp_occ));
            if (vecs[i].exp_out_vld)
                chk("vec_out_uid", 64'(cmd_out[34:3]), 64'(vecs[i].exp_uid));
        end

        // Fill to N with the engine stalled, then hold a fifth push.
        cmd_out_rdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_in(1'b1, 3'b001, 32'(10 + i));
            cyc();
        end
        chk("full_in_rdy", 64'(cmd_in_rdy), 64'd0);
        chk("full_occ",    64'(occupancy),  64'd4);
        set_in(1'b1, 3'b001, 32'd14);
        cyc();
        cyc();
        chk("full_hold_occ", 64'(occupancy), 64'd4);
        chk("full_head",     64'(cmd_out[34:3]), 64'd10);
        cmd_out_rdy = 1'b1;
        cyc();
        chk("pop_occ",    64'(occupancy),  64'd3);
        chk("pop_in_rdy", 64'(cmd_in_rdy), 64'd1);
        cmd_out_rdy = 1'b0;
        cyc();
        chk("acc14_occ", 64'(occupancy), 64'd4);
        set_in(1'b0, 3'b000, 32'd0);
        cmd_out_rdy = 1'b1;
        drain_exp = '{32'd11, 32'd12, 32'd13, 32'd14};
        for (int i = 0; i < 4; i++) begin
            chk("drain_uid", 64'(cmd_out[34:3]), 64'(drain_exp[i]));
            cyc();
        end
        chk("drain_occ", 64'(occupancy), 64'd0);

        // Nop response with the consumer stalled; a Buy is held behind it.
        cmd_out_rdy = 1'b0;
        set_in(1'b1, 3'b000, 32'hDEAD);
        cyc();
        chk("nop_rsp", 64'(rsp_out), {29'd0, 32'hDEAD, 3'b000});
        set_in(1'b1, 3'b001, 32'h77);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("nop_in_rdy",  64'(cmd_in_rdy),  64'd0);
            chk("nop_rsp_vld", 64'(rsp_out_vld), 64'd1);
            chk("nop_occ",     64'(occupancy),   64'd0);
        end
        rsp_out_rdy = 1'b1;
        cyc();
        chk("nop_clr_vld", 64'(rsp_out_vld), 64'd0);
        chk("nop_clr_rdy", 64'(cmd_in_rdy),  64'd1);
        chk("nop_clr_occ", 64'(occupancy),   64'd0);
        rsp_out_rdy = 1'b0;
        cyc();
        chk("after_nop_occ", 64'(occupancy), 64'd1);
        set_in(1'b0, 3'b000, 32'd0);
        cmd_out_rdy = 1'b1;
        cyc();

        // Reserved opcode dropped, following Buy forwarded.
        cmd_out_rdy = 1'b0;
        set_in(1'b1, 3'b101, 32'd7);
        cyc();
        set_in(1'b1, 3'b001, 32'd8);
        cyc();
        set_in(1'b0, 3'b000, 32'd0);
        chk("drop_cnt1", 64'(drop_cnt), 64'd1);
        chk("drop_occ",  64'(occupancy), 64'd1);
        chk("drop_head", 64'(cmd_out), {29'd0, 32'd8, 3'b001});
        cmd_out_rdy = 1'b1;
        cyc();

        // Saturate the drop counter.
        set_in(1'b1, 3'b110, 32'd9);
        while (m_drop < 65534) cyc();
        chk("drop_fffe", 64'(drop_cnt), 64'hFFFE);
        cyc();
        chk("drop_ffff", 64'(drop_cnt), 64'hFFFF);
        cyc();
        chk("drop_sat",  64'(drop_cnt), 64'hFFFF);
        set_in(1'b0, 3'b000, 32'd0);

        // Steady push+pop at occupancy 2 across two pointer wraps.
        cmd_out_rdy = 1'b0;
        set_in(1'b1, 3'b001, 32'd100);
        cyc();
        set_in(1'b1, 3'b010, 32'd101);
        cyc();
        cmd_out_rdy = 1'b1;
        for (int i = 0; i < 2 * N; i++) begin
            chk("wrap_head", 64'(cmd_out[34:3]), 64'(100 + i));
            set_in(1'b1, 3'b001, 32'(102 + i));
            cyc();
            chk("wrap_occ", 64'(occupancy), 64'd2);
        end
        set_in(1'b0, 3'b000, 32'd0);
        exp_uid = 100 + 2 * N;
        while (m_q.size() > 0) begin
            chk("wrap_tail", 64'(cmd_out[34:3]), 64'(exp_uid));
            exp_uid++;
            cyc();
        end

        // Asynchronous reset with 3 queued commands and a pending Nop.
        cmd_out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 3'b011, 32'(200 + i));
            cyc();
        end
        set_in(1'b1, 3'b000, 32'hBEEF);
        cyc();
        set_in(1'b0, 3'b000, 32'd0);
        chk("pre_rst_occ", 64'(occupancy),   64'd3);
        chk("pre_rst_rsp", 64'(rsp_out_vld), 64'd1);
        #3 arst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_out_vld", 64'(cmd_out_vld), 64'd0);
        chk("arst_occ",     64'(occupancy),   64'd0);
        chk("arst_rsp_vld", 64'(rsp_out_vld), 64'd0);
        chk("arst_rsp",     64'(rsp_out),     64'd0);
        chk("arst_drop",    64'(drop_cnt),    64'd0);
        chk("arst_in_rdy",  64'(cmd_in_rdy),  64'd1);
        #2 arst_n = 1'b1;
        cmd_out_rdy = 1'b1;
        rsp_out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst_out_vld", 64'(cmd_out_vld), 64'd0);
            chk("post_rst_rsp_vld", 64'(rsp_out_vld), 64'd0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(1, 3))
                                            : 3'($urandom_range(0, 7));
            set_in(1'($urandom_range(0, 9) < 7), op, $urandom);
            cmd_out_rdy = 1'($urandom_range(0, 9) < 5);
            rsp_out_rdy = 1'($urandom_range(0, 9) < 4);
            cyc();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
